ff_pipeline: RTL and testbench
==============================

Name: ff_pipeline

Overview:
- Parametrised registered delay line for fixed-latency alignment of datapath signals. Generalises the fixed 3-stage flip-flop chain to DEPTH stages.
- Adds per-stage valid tracking, a global stall enable, a synchronous flush and a runtime-selectable output tap.
- Adds a registered occupancy count so upstream logic can tell when the line has drained.

Parameters:
- WIDTH, 4, data bits per stage (>=1)
- DEPTH, 3, number of register stages (>=1)
- RESET_VAL, '0, value loaded into every data stage on reset and flush (WIDTH bits)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en_i  input  1  advance enable; 0 = all stages hold
- flush_i  input  1  synchronous clear of all stages and the count
- valid_i  input  1  qualifies data_i for stage 0
- data_i  input  WIDTH  input sample
- tap_sel_i  input  TAP_W  output stage select; delay = tap_sel_i+1 cycles
- valid_o  output  1  valid bit of the selected stage
- data_o  output  WIDTH  data of the selected stage
- occ_o  output  CNT_W  number of stages currently holding valid=1

Behaviour:
- Widths: TAP_W = max(1, clog2(DEPTH)); CNT_W = clog2(DEPTH+1).
- Storage per stage k (0..DEPTH-1): data_q[k] and valid_q[k].
- Reset (rst=1, asynchronous, any cycle, including mid-stream):
  - data_q[*]=RESET_VAL, valid_q[*]=0, occ=0.
  - Outputs therefore read data_o=RESET_VAL, valid_o=0, occ_o=0 immediately, with no clock edge needed.
- Priority at each posedge: flush_i, then en_i, then hold.
- flush_i=1:
  - All data_q=RESET_VAL, valid_q=0, occ=0.
  - The concurrent data_i/valid_i is discarded, regardless of en_i.
- en_i=1, flush_i=0:
  - data_q[0]<=data_i, valid_q[0]<=valid_i.
  - data_q[k]<=data_q[k-1] and valid_q[k]<=valid_q[k-1] for k>=1.
  - Data shifts even when valid_i=0; bubbles carry valid=0.
- en_i=0, flush_i=0: every stage and occ hold their values.
- Output mux (combinational, no added latency):
  - data_o=data_q[s], valid_o=valid_q[s], where s=tap_sel_i.
  - If tap_sel_i>=DEPTH, s is clamped to DEPTH-1.
  - tap_sel_i may change any cycle; the output follows the same cycle.
- Latency: with en_i held 1, a sample presented before edge n appears at tap t after edge n+t, i.e. t+1 cycles. DEPTH=3 with tap 2 gives the legacy 3-cycle chain.
- Occupancy:
  - occ is a registered counter, not a popcount.
  - On an advance: occ <= occ + valid_i - valid_q[DEPTH-1]. Entering and exiting valids in the same cycle leave occ unchanged.
  - occ never exceeds DEPTH and never underflows.
  - occ_o=occ must equal popcount(valid_q) every cycle; the verification engineer checks this with an assertion.
- DEPTH=1:
  - tap_sel_i is 1 bit and is always clamped to 0.
  - occ_o is 1 bit.

Decomposition:
- Shared package ff_pkg:
  - function safe_clog2(n), returning at least 1.
  - localparam-style helpers for TAP_W and CNT_W.
- Sub-module ff_stage: one WIDTH-bit data register plus valid bit, with async rst, sync clear and enable, reset value RESET_VAL. ff_pipeline instantiates it DEPTH times in a generate loop.
- Top level holds the output mux, the clamp and the occupancy counter.

Test Plan:
- Reset: assert rst mid-cycle with DEPTH=3, WIDTH=4, RESET_VAL=4'h0 -> data_o=0, valid_o=0 and occ_o=0 without waiting for a clock edge.
- Streaming: en_i=1, tap_sel_i=2, drive valid data 1,2,3,4 on consecutive cycles -> data_o=1 with valid_o=1 three edges after the first sample, then 2,3,4. occ_o counts 1,2,3 and stays at 3.
- Stall: after loading 5,6,7, hold en_i=0 for 4 cycles while driving 9 -> data_o stays 5 and occ_o stays 3. With en_i=1 again, the next edge gives data_o=6.
- Flush: with 3 valid entries, assert flush_i and en_i together with valid_i=1, data_i=A -> next cycle valid_o=0, occ_o=0 and data_o=RESET_VAL. The value A is not captured.
- Tap change and clamp, DEPTH=3, line holding 7 (stage 0), 6 (stage 1), 5 (stage 2):
  - tap 0 -> data_o=7.
  - tap 1 -> data_o=6 in the same cycle.
  - tap 3 (out of range) -> clamped to stage 2, data_o=5.
- Bubbles and reset mid-stream: drive the valid pattern 1,0,1 -> occ_o goes 1,1,2 and tap-2 valid_o shows 1,0,1. Assert rst between samples -> all state clears, and a later sample emerges with the correct latency.

Source files
------------

// File: rtl/ff_pkg.sv
// Shared width helpers for the ff_pipeline delay line.
// Tap-select and occupancy widths are derived from DEPTH and are always at least 1 bit.
package ff_pkg;

  // Ceiling log2, never less than 1, so a DEPTH=1 line still has a 1-bit port.
  function automatic int safe_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int tap_width(input int depth);
    return safe_clog2(depth);
  endfunction

  // The count must be able to reach DEPTH itself.
  function automatic int cnt_width(input int depth);
    return safe_clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ff_stage.sv
// One delay-line stage: a WIDTH-bit data register plus its valid bit.
// Asynchronous reset, synchronous clear (wins over enable), and enable.
module ff_stage #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // NOTE: defaulting every output first keeps this block free of inferred latches.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clr_i) begin
      data_d  = RESET_VAL;
      valid_d = 1'b0;
    end else if (en_i) begin
      data_d  = data_i;
      valid_d = valid_i;
    end
  end

  // NOTE: non-blocking assignments let every stage sample its neighbour's old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= RESET_VAL;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/ff_pipeline.sv
// Parametrised registered delay line with per-stage valid, stall, flush,
// a clamped runtime output tap and a registered occupancy counter.
module ff_pipeline
  import ff_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en_i,
  input  logic                          flush_i,
  input  logic                          valid_i,
  input  logic [WIDTH-1:0]              data_i,
  input  logic [tap_width(DEPTH)-1:0]   tap_sel_i,
  output logic                          valid_o,
  output logic [WIDTH-1:0]              data_o,
  output logic [cnt_width(DEPTH)-1:0]   occ_o
);

  localparam int CNT_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] data_q  [DEPTH];
  logic             valid_q [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] stage_data;
    logic             stage_valid;

    if (k == 0) begin : g_head
      assign stage_data  = data_i;
      assign stage_valid = valid_i;
    end else begin : g_body
      assign stage_data  = data_q[k-1];
      assign stage_valid = valid_q[k-1];
    end

    ff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (flush_i),
      .en_i    (en_i),
      .valid_i (stage_valid),
      .data_i  (stage_data),
      .valid_o (valid_q[k]),
      .data_o  (data_q[k])
    );
  end

  // Out-of-range taps read the last stage; a loop mux avoids sizing the index to the array.
  int sel;
  always_comb begin
    sel     = (int'(tap_sel_i) > DEPTH - 1) ? DEPTH - 1 : int'(tap_sel_i);
    data_o  = data_q[0];
    valid_o = valid_q[0];
    for (int k = 1; k < DEPTH; k++) begin
      if (sel == k) begin
        data_o  = data_q[k];
        valid_o = valid_q[k];
      end
    end
  end

  // Counter tracks entries/exits rather than summing the valid bits each cycle.
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             valid_last;

  assign valid_last = valid_q[DEPTH-1];

  always_comb begin
    occ_d = occ_q;
    if (flush_i) begin
      occ_d = '0;
    end else if (en_i) begin
      if (valid_i && !valid_last) begin
        occ_d = occ_q + CNT_W'(1);
      end else if (!valid_i && valid_last) begin
        occ_d = occ_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ_o = occ_q;

endmodule

// File: tb/tb_ff_pipeline.sv
// Self-checking bench for ff_pipeline (DEPTH=3, WIDTH=4, RESET_VAL=0): directed
// plan steps followed by random traffic, compared against a history-queue model.
module tb_ff_pipeline;

  localparam int               WIDTH     = 4;
  localparam int               DEPTH     = 3;
  localparam logic [WIDTH-1:0] RESET_VAL = '0;

  logic             clk;
  logic             rst;
  logic             en_i;
  logic             flush_i;
  logic             valid_i;
  logic [WIDTH-1:0] data_i;
  logic [1:0]       tap_sel_i;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic [1:0]       occ_o;

  int n_checks;
  int n_fail;

  ff_pipeline #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (RESET_VAL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en_i),
    .flush_i   (flush_i),
    .valid_i   (valid_i),
    .data_i    (data_i),
    .tap_sel_i (tap_sel_i),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .occ_o     (occ_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: hist[t] is the sample accepted t advances ago; the line shows the newest DEPTH.
  typedef struct {
    logic             v;
    logic [WIDTH-1:0] d;
  } entry_t;

  entry_t hist[$];

  task automatic model_reset();
    entry_t e;
    e.v = 1'b0;
    e.d = RESET_VAL;
    hist = {};
    for (int i = 0; i < DEPTH; i++) hist.push_back(e);
  endtask

  task automatic model_edge(input logic en, input logic fl, input logic v, input logic [WIDTH-1:0] d);
    entry_t e;
    if (fl) begin
      model_reset();
    end else if (en) begin
      e.v = v;
      e.d = d;
      hist.push_front(e);
      void'(hist.pop_back());
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int s;
    int occ;
    s = (int'(tap_sel_i) > DEPTH - 1) ? DEPTH - 1 : int'(tap_sel_i);
    occ = 0;
    foreach (hist[i]) if (hist[i].v) occ++;
    check({tag, ".data"},  32'(data_o),  32'(hist[s].d));
    check({tag, ".valid"}, 32'(valid_o), 32'(hist[s].v));
    check({tag, ".occ"},   32'(occ_o),   32'(occ));
  endtask

  // Drive one cycle's inputs, let the edge happen, then compare 1 ns later.
  task automatic tick(input string tag, input logic en, input logic fl,
                      input logic v, input logic [WIDTH-1:0] d);
    en_i    = en;
    flush_i = fl;
    valid_i = v;
    data_i  = d;
    @(posedge clk);
    model_edge(en, fl, v, d);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse(input string tag);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    en_i      = 1'b0;
    flush_i   = 1'b0;
    valid_i   = 1'b0;
    data_i    = '0;
    tap_sel_i = 2'd2;
    model_reset();
    #2;
    check_all("reset");
    rst = 1'b0;

    // Streaming 1..7; first sample reaches tap 2 after the third edge.
    for (int i = 1; i <= 7; i++) begin
      tick("stream", 1'b1, 1'b0, 1'b1, WIDTH'(i));
      if (i == 3) check("stream.first", 32'(data_o), 32'd1);
    end
    check("stream.occ_full", 32'(occ_o), 32'd3);

    // Stall while offering 9: nothing moves.
    for (int i = 0; i < 4; i++) begin
      tick("stall", 1'b0, 1'b0, 1'b1, 4'h9);
      check("stall.data", 32'(data_o), 32'd5);
    end

    // Tap changes take effect without a clock edge.
    tap_sel_i = 2'd0; #1; check("tap0", 32'(data_o), 32'd7); check_all("tap0");
    tap_sel_i = 2'd1; #1; check("tap1", 32'(data_o), 32'd6); check_all("tap1");
    tap_sel_i = 2'd3; #1; check("tap3_clamp", 32'(data_o), 32'd5); check_all("tap3");
    tap_sel_i = 2'd2;

    tick("resume", 1'b1, 1'b0, 1'b1, 4'h8);
    check("resume.data", 32'(data_o), 32'd6);

    // Flush with enable and a valid offer: the offered sample is dropped.
    tick("flush", 1'b1, 1'b1, 1'b1, 4'hA);
    check("flush.occ", 32'(occ_o), 32'd0);
    tap_sel_i = 2'd0; #1; check("flush.head", 32'(data_o), 32'(RESET_VAL)); tap_sel_i = 2'd2;

    // Bubbles: valid pattern 1,0,1 then drain.
    tick("bubble", 1'b1, 1'b0, 1'b1, 4'h3);
    tick("bubble", 1'b1, 1'b0, 1'b0, 4'hF);
    tick("bubble", 1'b1, 1'b0, 1'b1, 4'h5);
    check("bubble.occ", 32'(occ_o), 32'd2);
    check("bubble.v0", 32'(valid_o), 32'd1);
    tick("bubble", 1'b1, 1'b0, 1'b0, 4'h0);
    check("bubble.v1", 32'(valid_o), 32'd0);
    tick("bubble", 1'b1, 1'b0, 1'b0, 4'h0);
    check("bubble.v2", 32'(valid_o), 32'd1);

    // Reset mid-stream, then check latency of a fresh sample.
    reset_pulse("rst_mid");
    tick("post_rst", 1'b1, 1'b0, 1'b1, 4'hC);
    tick("post_rst", 1'b1, 1'b0, 1'b0, 4'h1);
    check("post_rst.early", 32'(valid_o), 32'd0);
    tick("post_rst", 1'b1, 1'b0, 1'b0, 4'h2);
    check("post_rst.data", 32'(data_o), 32'hC);
    check("post_rst.valid", 32'(valid_o), 32'd1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      tap_sel_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) begin
        reset_pulse("rnd_rst");
      end else begin
        tick("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0),
             1'($urandom), WIDTH'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
